mv_control_fsm: RTL and testbench
=================================

Name: mv_control_fsm

Overview:
- Sequencing controller for the 4x4 matrix-vector multiplier datapath.
- After a start pulse it loads the matrix memory X (16 words) and the vector memory A (4 words) from the external input stream, one word per cycle.
- It then walks the four row dot-products, driving memory addresses, accumulator clear and Y-memory writes, and pulses done.
- It sits beside the datapath (X/A/Y memories plus multiply-accumulate) and owns all of that datapath's control.

Parameters:
- None. Dimensions are fixed at 4 rows x 4 columns by shared package constants.

Ports:
- clk        input   1  rising-edge clock
- reset      input   1  asynchronous, active-high reset
- start      input   1  begin one load-and-compute run; sampled only in IDLE
- addr_x     output  4  X memory address; element (r,k) is at 4*r+k
- wr_en_x    output  1  X memory write enable
- addr_a     output  2  A memory address
- wr_en_a    output  1  A memory write enable
- addr_y     output  2  Y memory address
- wr_en_y    output  1  Y memory write enable
- clear_acc  output  1  synchronous accumulator clear
- done       output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, all counters 0, every output 0. Reset asserted mid-run aborts immediately; there is no resume.
- Datapath contract:
  - Memories have a registered read with 1-cycle latency.
  - The accumulator is free-running: acc <= acc + x*a every cycle, and acc <= 0 when clear_acc=1.
- States: IDLE, LOAD_X, LOAD_A, MAC, DRAIN, WRITE_Y, DONE. All outputs are registered or decoded from state and counters only, with no combinational path from start.
- IDLE: outputs 0. If start=1 at a clock edge, go to LOAD_X with the counter at 0. start in any other state is ignored.
- LOAD_X: 16 cycles, wr_en_x=1, addr_x=0..15 (one per cycle). After addr_x=15, go to LOAD_A.
- LOAD_A: 4 cycles, wr_en_a=1, addr_a=0..3. After addr_a=3, go to MAC with row r=0 and k=0.
- MAC: 4 cycles, k=0..3.
  - addr_x=4r+k, addr_a=k.
  - clear_acc=1 only in the k=0 cycle.
  - After k=3, go to DRAIN.
- DRAIN: 1 cycle, all enables 0. The k=3 product is accumulated at the end of this cycle.
- WRITE_Y: 1 cycle, wr_en_y=1, addr_y=r. The datapath writes the current acc to Y[r]. Then:
  - if r<3: r++, go to MAC (k=0);
  - if r=3: go to DONE.
- DONE: 1 cycle, done=1, then IDLE. A start seen in the DONE cycle is ignored.
- Address outputs outside their active state: addr_x, addr_a and addr_y hold 0 when not in use.
- Write enables are mutually exclusive. wr_en_x and wr_en_a are never high during compute.
- Timing, with the start-sample edge as cycle 0:
  - LOAD_X is cycles 1-16.
  - LOAD_A is cycles 17-20.
  - Row r occupies cycles 21+6r to 26+6r.
  - done=1 in cycle 45.
  - The next start is accepted from cycle 46 (IDLE).
- Counter widths: 4-bit load counter, 2-bit k, 2-bit r. All counters wrap only under explicit state control, never implicitly.

Decomposition:
- Package mv_pkg holds:
  - constants N_ROWS=4, N_COLS=4, X_AW=4, A_AW=2, Y_AW=2;
  - the state enum type (IDLE..DONE).
- Single module, no sub-modules. The counters and next-state logic are small enough to live inline.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then release with start=0 for 10 cycles -> all outputs 0 and done never high.
- Full run: start pulsed for 1 cycle ->
  - wr_en_x=1 with addr_x 0..15 in cycles 1-16;
  - wr_en_a=1 with addr_a 0..3 in cycles 17-20;
  - clear_acc in cycles 21/27/33/39;
  - wr_en_y with addr_y 0/1/2/3 in cycles 26/32/38/44;
  - done=1 only in cycle 45.
- Address pattern: during row 2 MAC (cycles 33-36) -> addr_x=8,9,10,11 and addr_a=0,1,2,3.
- Start ignored while busy: hold start=1 through the whole run -> identical timing, and a new run begins only from cycle 46.
- Mid-run reset: assert reset asynchronously in cycle 30 (between clock edges) -> outputs go to 0 immediately and state=IDLE. A fresh start then gives the full-run timing again.
- Exclusivity check over the full run: at most one of wr_en_x, wr_en_a and wr_en_y is high in any cycle, and clear_acc is never high in the same cycle as wr_en_y.

Source files
------------

// File: rtl/mv_pkg.sv
// Shared dimensions and state type for the 4x4 matrix-vector multiplier control.
package mv_pkg;

   localparam int unsigned N_ROWS = 4;
   localparam int unsigned N_COLS = 4;
   localparam int unsigned X_AW   = 4;
   localparam int unsigned A_AW   = 2;
   localparam int unsigned Y_AW   = 2;

   typedef enum logic [2:0] {
      StIdle,
      StLoadX,
      StLoadA,
      StMac,
      StDrain,
      StWriteY,
      StDone
   } state_e;

endpackage

// File: rtl/mv_control_fsm.sv
// Sequencer for the 4x4 matrix-vector datapath: loads X and A, walks the four
// row dot-products, writes Y and pulses done. All outputs are registered.
module mv_control_fsm
   import mv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [X_AW-1:0] addr_x,
   output logic            wr_en_x,
   output logic [A_AW-1:0] addr_a,
   output logic            wr_en_a,
   output logic [Y_AW-1:0] addr_y,
   output logic            wr_en_y,
   output logic            clear_acc,
   output logic            done
);

   state_e          state_q, state_d;
   logic [X_AW-1:0] ld_q, ld_d;
   logic [A_AW-1:0] k_q, k_d;
   logic [Y_AW-1:0] r_q, r_d;

   logic [X_AW-1:0] addr_x_d;
   logic            wr_en_x_d;
   logic [A_AW-1:0] addr_a_d;
   logic            wr_en_a_d;
   logic [Y_AW-1:0] addr_y_d;
   logic            wr_en_y_d;
   logic            clear_acc_d;
   logic            done_d;

   always_comb begin
      state_d = state_q;
      ld_d    = ld_q;
      k_d     = k_q;
      r_d     = r_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoadX;
               ld_d    = '0;
            end
         end
         StLoadX: begin
            if (ld_q == X_AW'(N_ROWS * N_COLS - 1)) begin
               state_d = StLoadA;
               ld_d    = '0;
            end else begin
               ld_d = ld_q + X_AW'(1);
            end
         end
         StLoadA: begin
            if (ld_q == X_AW'(N_COLS - 1)) begin
               state_d = StMac;
               ld_d    = '0;
               k_d     = '0;
               r_d     = '0;
            end else begin
               ld_d = ld_q + X_AW'(1);
            end
         end
         StMac: begin
            if (k_q == A_AW'(N_COLS - 1)) begin
               state_d = StDrain;
               k_d     = '0;
            end else begin
               k_d = k_q + A_AW'(1);
            end
         end
         StDrain: state_d = StWriteY;
         StWriteY: begin
            k_d = '0;
            if (r_q == Y_AW'(N_ROWS - 1)) begin
               state_d = StDone;
               r_d     = '0;
            end else begin
               state_d = StMac;
               r_d     = r_q + Y_AW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so that they register in step with it.
   always_comb begin
      addr_x_d    = '0;
      wr_en_x_d   = 1'b0;
      addr_a_d    = '0;
      wr_en_a_d   = 1'b0;
      addr_y_d    = '0;
      wr_en_y_d   = 1'b0;
      clear_acc_d = 1'b0;
      done_d      = 1'b0;
      unique case (state_d)
         StLoadX: begin
            wr_en_x_d = 1'b1;
            addr_x_d  = ld_d;
         end
         StLoadA: begin
            wr_en_a_d = 1'b1;
            addr_a_d  = ld_d[A_AW-1:0];
         end
         StMac: begin
            addr_x_d    = {r_d, k_d};
            addr_a_d    = k_d;
            clear_acc_d = (k_d == '0);
         end
         StWriteY: begin
            wr_en_y_d = 1'b1;
            addr_y_d  = r_d;
         end
         StDone:  done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         ld_q      <= '0;
         k_q       <= '0;
         r_q       <= '0;
         addr_x    <= '0;
         wr_en_x   <= 1'b0;
         addr_a    <= '0;
         wr_en_a   <= 1'b0;
         addr_y    <= '0;
         wr_en_y   <= 1'b0;
         clear_acc <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         ld_q      <= ld_d;
         k_q       <= k_d;
         r_q       <= r_d;
         addr_x    <= addr_x_d;
         wr_en_x   <= wr_en_x_d;
         addr_a    <= addr_a_d;
         wr_en_a   <= wr_en_a_d;
         addr_y    <= addr_y_d;
         wr_en_y   <= wr_en_y_d;
         clear_acc <= clear_acc_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_mv_control_fsm.sv
// Self-checking bench for mv_control_fsm against a cycle-index reference model.
module tb_mv_control_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [3:0] addr_x;
   logic       wr_en_x;
   logic [1:0] addr_a;
   logic       wr_en_a;
   logic [1:0] addr_y;
   logic       wr_en_y;
   logic       clear_acc;
   logic       done;

   logic [13:0] obs;
   int          t = 0;
   int          errors = 0;
   int          checks = 0;

   mv_control_fsm dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .addr_x    (addr_x),
      .wr_en_x   (wr_en_x),
      .addr_a    (addr_a),
      .wr_en_a   (wr_en_a),
      .addr_y    (addr_y),
      .wr_en_y   (wr_en_y),
      .clear_acc (clear_acc),
      .done      (done)
   );

   always #5 clk = ~clk;

   assign obs = {addr_x, wr_en_x, addr_a, wr_en_a, addr_y, wr_en_y, clear_acc, done};

   // Expected outputs in cycle t of a run (t=0 means idle, t=1 is the first LOAD_X cycle).
   function automatic logic [13:0] exp_out(input int tt);
      logic [3:0] ax;
      logic [1:0] aa, ay;
      logic       wx, wa, wy, clr, dn;
      int         p, r, s;
      ax = '0; aa = '0; ay = '0; wx = 0; wa = 0; wy = 0; clr = 0; dn = 0;
      if (tt >= 1 && tt <= 16) begin
         wx = 1'b1;
         ax = 4'(tt - 1);
      end else if (tt >= 17 && tt <= 20) begin
         wa = 1'b1;
         aa = 2'(tt - 17);
      end else if (tt >= 21 && tt <= 44) begin
         p = tt - 21;
         r = p / 6;
         s = p % 6;
         if (s < 4) begin
            ax  = 4'(4 * r + s);
            aa  = 2'(s);
            clr = (s == 0);
         end else if (s == 5) begin
            wy = 1'b1;
            ay = 2'(r);
         end
      end else if (tt == 45) begin
         dn = 1'b1;
      end
      return {ax, wx, aa, wa, ay, wy, clr, dn};
   endfunction

   task automatic cycle(input logic s, input string tag);
      logic [13:0] e;
      start = s;
      @(posedge clk);
      if (reset) t = 0;
      else if (t == 0) t = s ? 1 : 0;
      else if (t >= 45) t = 0;
      else t = t + 1;
      @(negedge clk);
      e = exp_out(t);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL %s t=%0d: outputs got %h expected %h", tag, t, obs, e);
      end
      checks++;
      if (($countones({wr_en_x, wr_en_a, wr_en_y}) > 1) || (clear_acc && wr_en_y)) begin
         errors++;
         $display("FAIL %s_excl t=%0d: enables x/a/y/clr got %b%b%b%b expected exclusive",
                  tag, t, wr_en_x, wr_en_a, wr_en_y, clear_acc);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (obs !== 14'h0) begin
         errors++;
         $display("FAIL reset_state: outputs got %h expected 0", obs);
      end
      t = 0;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) cycle(1'b0, "idle");
   endtask

   task automatic test_full_run;
      cycle(1'b1, "full_start");
      for (int i = 0; i < 47; i++) cycle(1'b0, "full_run");
   endtask

   task automatic test_start_held;
      // Held start: second run begins when sampled again in IDLE at cycle 46.
      for (int i = 0; i < 47; i++) cycle(1'b1, "held");
      for (int i = 0; i < 48; i++) cycle(1'b0, "held_tail");
   endtask

   task automatic test_random_start;
      for (int i = 0; i < 300; i++) cycle(1'($urandom_range(0, 3) == 0), "rand");
      for (int i = 0; i < 48; i++) cycle(1'b0, "rand_tail");
   endtask

   task automatic test_mid_reset;
      cycle(1'b1, "mid_start");
      for (int i = 0; i < 29; i++) cycle(1'b0, "mid_run");
      #2 reset = 1'b1;
      #1;
      checks++;
      if (obs !== 14'h0) begin
         errors++;
         $display("FAIL mid_reset_async: outputs got %h expected 0", obs);
      end
      t = 0;
      cycle(1'b1, "mid_in_reset");
      cycle(1'b0, "mid_in_reset");
      reset = 1'b0;
      cycle(1'b0, "mid_idle");
      test_full_run();
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_start_held();
      test_random_start();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
